// File: rtl/switch_game_pkg.sv
// ---------------------------------------------------------------------------
// switch_game_pkg
// Shared definitions for the switch game round controller:
//   - state_t    : FSM state encoding, also exported on state_o
//   - ROUND_W    : width of the passed-round counter
//   - LFSR_POLY  : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - lfsr_step  : one right-shifting Galois step of the prompt generator
// ---------------------------------------------------------------------------
package switch_game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PROMPT = 3'd1,
    PLAY   = 3'd2,
    PASS   = 3'd3,
    GAP    = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam int ROUND_W = 8;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // A right-shifting Galois LFSR: the bit shifted out decides whether the
  // feedback mask is folded back into the register.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = {1'b0, s[15:1]};
    return s[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

endpackage

// File: rtl/switch_tick_gen.sv
// ---------------------------------------------------------------------------
// switch_tick_gen
// Divides the system clock down to the 1 s game tick.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   clr      in   synchronous clear, restarts the current second
//   tick     out  high for one cycle every TICK_DIV cycles
// ---------------------------------------------------------------------------
module switch_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The tick is taken from the last count of a second, so the first tick
  // after a clear arrives only after TICK_DIV full cycles.
  assign tick = (cnt_q == CNT_LAST);

  // Count up and wrap at the end of each second; a clear wins so a fresh
  // phase always starts at the beginning of a second.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/switch_round_ctrl.sv
// ---------------------------------------------------------------------------
// switch_round_ctrl
// Round controller for the switch game: prompts one random switch per round,
// times the round, judges the flip, and keeps the round count and score.
// Optional feature macro: ROUND_SPEEDUP_EN -- when defined, play time shrinks
// by one second per passed round down to MIN_PLAY_SEC.
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   start       in   start/restart level, rising edge used
//   sw          in   raw switches, synchronised internally
//   led_prompt  out  one-hot switch to flip this round
//   time_left   out  seconds remaining in current phase
//   round_cnt   out  rounds passed this game (saturating)
//   score       out  accumulated score (saturating)
//   state_o     out  current FSM state
//   round_pass  out  one-cycle pulse per passed round
//   game_over   out  high while in OVER
// ---------------------------------------------------------------------------
module switch_round_ctrl
  import switch_game_pkg::*;
#(
  parameter int          TICK_DIV      = 50_000_000,
  parameter int          NUM_SW        = 10,
  parameter int          TIME_W        = 6,
  parameter int          PLAY_SEC      = 15,
  parameter int          GAP_SEC       = 5,
  parameter int          MIN_PLAY_SEC  = 5,
  parameter int          PTS_PER_ROUND = 2,
  parameter int          BONUS_EVERY   = 5,
  parameter int          SCORE_W       = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_SW-1:0]   led_prompt,
  output logic [TIME_W-1:0]   time_left,
  output logic [7:0]          round_cnt,
  output logic [SCORE_W-1:0]  score,
  output logic [2:0]          state_o,
  output logic                round_pass,
  output logic                game_over
);

  localparam logic [NUM_SW-1:0] ONE_HOT_LSB = NUM_SW'(1);

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_SW-1:0]    sw_meta_q, sw_meta_d;
  logic [NUM_SW-1:0]    sw_sync_q, sw_sync_d;
  logic [NUM_SW-1:0]    led_q, led_d;
  logic [NUM_SW-1:0]    expect_q, expect_d;
  logic [NUM_SW-1:0]    snap_q, snap_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 start_prev_q, start_prev_d;

  logic                 start_rise;
  logic                 tick;
  logic                 tick_clr;
  logic [15:0]          lfsr_next;
  int                   prompt_idx;
  logic [NUM_SW-1:0]    prompt_onehot;
  int                   play_int;
  logic [TIME_W-1:0]    play_time;
  logic [ROUND_W-1:0]   round_inc;
  int                   bonus_shift;
  logic [SCORE_W:0]     pts;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  // Every state change restarts the second counter so each phase is given
  // whole seconds regardless of where the previous phase ended.
  switch_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

  assign tick_clr   = (state_d != state_q);
  assign start_rise = start & ~start_prev_q;

  // Input conditioning: two-flop synchroniser for the switches, and the
  // previous start level for edge detection.
  always_comb begin
    sw_meta_d    = sw;
    sw_sync_d    = sw_meta_q;
    start_prev_d = start;
  end

  // Prompt generation: step the LFSR once and pick a switch from its low
  // byte. The modulo keeps the index inside the switches actually in play.
  always_comb begin
    lfsr_next     = lfsr_step(lfsr_q);
    prompt_idx    = int'(lfsr_next[7:0]) % NUM_SW;
    prompt_onehot = ONE_HOT_LSB << prompt_idx;
  end

  // Play time for the upcoming round. With the speed-up option each passed
  // round takes a second off, but never below the floor.
`ifdef ROUND_SPEEDUP_EN
  always_comb begin
    play_int = PLAY_SEC - int'(round_q);
    if (play_int < MIN_PLAY_SEC) begin
      play_int = MIN_PLAY_SEC;
    end
    play_time = TIME_W'(play_int);
  end
`else
  always_comb begin
    play_int  = PLAY_SEC;
    play_time = TIME_W'(play_int);
  end
`endif

  // Scoring for a passed round. Base points double every BONUS_EVERY passed
  // rounds; the sum is formed one bit wider so overflow can be detected and
  // the score pinned at all-ones instead of wrapping. A shift that would
  // push every point out of range is treated as an overflow too.
  always_comb begin
    round_inc   = (round_q == '1) ? round_q : round_q + ROUND_W'(1);
    bonus_shift = int'(round_inc) / BONUS_EVERY;
    if (bonus_shift > SCORE_W) begin
      pts = (PTS_PER_ROUND != 0) ? '1 : '0;
    end else begin
      pts = (SCORE_W + 1)'(PTS_PER_ROUND) << bonus_shift;
    end
    score_sum = {1'b0, score_q} + pts;
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Main round FSM. Each one-cycle state (PROMPT, PASS) does its bookkeeping
  // on its way out, so the results are visible in the following state.
  // In PLAY a correct flip is checked before a wrong flip and before the
  // timeout, so a correct flip landing on the last tick still counts.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    led_d    = led_q;
    expect_d = expect_q;
    snap_d   = snap_q;
    time_d   = time_q;
    round_d  = round_q;
    score_d  = score_q;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = PROMPT;
        end
      end

      PROMPT: begin
        lfsr_d   = lfsr_next;
        led_d    = prompt_onehot;
        expect_d = sw_sync_q ^ prompt_onehot;
        snap_d   = sw_sync_q;
        time_d   = play_time;
        state_d  = PLAY;
      end

      PLAY: begin
        if (sw_sync_q == expect_q) begin
          state_d = PASS;
        end else if (sw_sync_q != snap_q) begin
          led_d   = '0;
          state_d = OVER;
        end else if (tick && (time_q == TIME_W'(1))) begin
          time_d  = '0;
          led_d   = '0;
          state_d = OVER;
        end else if (tick) begin
          time_d = time_q - TIME_W'(1);
        end
      end

      PASS: begin
        round_d = round_inc;
        score_d = score_sat;
        led_d   = '0;
        time_d  = TIME_W'(GAP_SEC);
        state_d = GAP;
      end

      GAP: begin
        if (tick) begin
          time_d = time_q - TIME_W'(1);
          if (time_q == TIME_W'(1)) begin
            state_d = PROMPT;
          end
        end
      end

      OVER: begin
        if (start_rise) begin
          score_d = '0;
          round_d = '0;
          state_d = PROMPT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. The start history resets high so a key already held
  // during reset is not mistaken for a fresh start request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      led_q        <= '0;
      expect_q     <= '0;
      snap_q       <= '0;
      time_q       <= '0;
      round_q      <= '0;
      score_q      <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      led_q        <= led_d;
      expect_q     <= expect_d;
      snap_q       <= snap_d;
      time_q       <= time_d;
      round_q      <= round_d;
      score_q      <= score_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign led_prompt = led_q;
  assign time_left  = time_q;
  assign round_cnt  = round_q;
  assign score      = score_q;
  assign state_o    = state_q;
  assign round_pass = (state_q == PASS);
  assign game_over  = (state_q == OVER);

endmodule
